// File: rtl/barrel_shift_arb_pkg.sv
// Shared defaults and helpers for the round-robin rotate arbiter.
package barrel_shift_arb_pkg;

  localparam int BIT_DEF  = 8;
  localparam int NREQ_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int field_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/barrel_shift.sv
// Combinational rotator; left/right, amount taken modulo BIT.
module barrel_shift #(
  parameter int BIT = 8,
  localparam int SW = $clog2(BIT)
) (
  input  logic [BIT-1:0] i_data,
  input  logic           i_left,
  input  logic [SW-1:0]  i_shift,
  output logic [BIT-1:0] o_data
);

  logic [SW-1:0] amt;
  logic [SW-1:0] back;

  // Left by s equals right by (BIT - s); BIT wraps to 0 in SW bits.
  assign amt    = i_left ? (SW'(0) - i_shift) : i_shift;
  assign back   = SW'(0) - amt;
  assign o_data = (i_data >> amt) | (i_data << back);

endmodule

// File: rtl/barrel_shift_arb.sv
// Round-robin arbiter sharing one rotator among NREQ requesters.
module barrel_shift_arb
  import barrel_shift_arb_pkg::*;
#(
  parameter int BIT  = BIT_DEF,
  parameter int NREQ = NREQ_DEF,
  localparam int SW  = idx_w(BIT),
  localparam int IW  = idx_w(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*BIT-1:0] i_req_data,
  input  logic [NREQ-1:0]   i_req_left,
  input  logic [NREQ*SW-1:0] i_req_shift,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [BIT-1:0]    o_rsp_data,
  output logic [IW-1:0]     o_rsp_id,
  output logic              o_busy
);

  logic           rsp_valid_q, rsp_valid_d;
  logic [BIT-1:0] rsp_data_q, rsp_data_d;
  logic [IW-1:0]  rsp_id_q, rsp_id_d;
  logic [IW-1:0]  ptr_q, ptr_d;

  logic           slot_free;
  logic           gnt_found;
  logic [IW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic           accept;

  logic [BIT-1:0] sel_data;
  logic           sel_left;
  logic [SW-1:0]  sel_shift;
  logic [BIT-1:0] rot_data;

  assign slot_free = !rsp_valid_q | i_rsp_ready;

  // Lowest valid overall is the wrap-around fallback; lowest at/after ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req_valid[k] && (IW'(k) >= ptr_q)) begin
        gnt_idx = IW'(k);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_found && slot_free && i_rstn) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign accept      = |gnt_oh;
  assign o_req_ready = gnt_oh;

  always_comb begin
    sel_data  = '0;
    sel_left  = 1'b0;
    sel_shift = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == gnt_idx) begin
        sel_data  = i_req_data[field_lsb(k, BIT) +: BIT];
        sel_left  = i_req_left[k];
        sel_shift = i_req_shift[field_lsb(k, SW) +: SW];
      end
    end
  end

  barrel_shift #(
    .BIT (BIT)
  ) u_rot (
    .i_data  (sel_data),
    .i_left  (sel_left),
    .i_shift (sel_shift),
    .o_data  (rot_data)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rot_data;
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_busy      = rsp_valid_q | (|i_req_valid);

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Directed-vector bench for the round-robin rotate arbiter.
module tb_barrel_shift_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [3:0]  req_left;
  logic [11:0] req_shift;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  barrel_shift_arb #(
    .BIT  (8),
    .NREQ (4)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_data  (req_data),
    .i_req_left  (req_left),
    .i_req_shift (req_shift),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .o_busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d,
                         input logic l, input logic [2:0] s);
    req_valid[k]        = v;
    req_data[k*8 +: 8]  = d;
    req_left[k]         = l;
    req_shift[k*3 +: 3] = s;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_left  = '0;
    req_shift = '0;
    set_req(0, 1'b1, 8'hFF, 1'b1, 3'd1);
    tick();
    tick();
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b id=%0d d=%h want 0/0/00",
               rsp_valid, rsp_id, rsp_data);
    end
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy_req: got %b want 1", busy);
    end
    req_valid = '0;
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_idle: got %b want 0", busy);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(2, 1'b1, 8'h81, 1'b1, 3'd1);
    #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 8'h03}) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b id=%0d d=%h want 1/2/03",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b0, 2'd2, 8'h03}) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b id=%0d d=%h want 0/2/03",
               rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] din [3];
    logic       lft [3];
    logic [2:0] sh  [3];
    logic [7:0] exp [3];
    din = '{8'h01, 8'hA5, 8'h96};
    lft = '{1'b0, 1'b1, 1'b0};
    sh  = '{3'd1, 3'd0, 3'd7};
    exp = '{8'h80, 8'hA5, 8'h2D};
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, din[i], lft[i], sh[i]);
      #1;
      n_chk++;
      if (req_ready !== 4'b0001) begin
        n_fail++;
        $display("FAIL rot_ready[%0d]: got %b want 0001", i, req_ready);
      end
      tick();
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, exp[i]}) begin
        n_fail++;
        $display("FAIL rot_rsp[%0d]: got v=%b id=%0d d=%h want 1/0/%h",
                 i, rsp_valid, rsp_id, rsp_data, exp[i]);
      end
    end
    req_valid[0] = 1'b0;
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rot_drain: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp [4];
    logic [3:0] oh;
    exp = '{8'h11, 8'h44, 8'hCC, 8'h22};
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    tick();
    set_req(0, 1'b1, 8'h11, 1'b1, 3'd0);
    set_req(1, 1'b1, 8'h22, 1'b1, 3'd1);
    set_req(2, 1'b1, 8'h33, 1'b1, 3'd2);
    set_req(3, 1'b1, 8'h44, 1'b1, 3'd3);
    for (int i = 0; i < 6; i++) begin
      oh = 4'b0001 << (i % 4);
      #1;
      n_chk++;
      if (req_ready !== oh) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, oh);
      end
      tick();
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(i % 4), exp[i % 4]}) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%h want 1/%0d/%h",
                 i, rsp_valid, rsp_id, rsp_data, i % 4, exp[i % 4]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b1, 8'h81, 1'b1, 3'd1);
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_first_ready: got %b want 0001", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    rsp_ready    = 1'b0;
    set_req(1, 1'b1, 8'h0F, 1'b1, 3'd4);
    set_req(3, 1'b1, 8'h12, 1'b0, 3'd4);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++;
      if ({req_ready, rsp_valid, rsp_id, rsp_data} !==
          {4'b0000, 1'b1, 2'd0, 8'h03}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d d=%h want 0000/1/0/03",
                 c, req_ready, rsp_valid, rsp_id, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 0010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'hF0}) begin
      n_fail++;
      $display("FAIL bp_rsp1: got v=%b id=%0d d=%h want 1/1/F0",
               rsp_valid, rsp_id, rsp_data);
    end
    #1;
    n_chk++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_ready3: got %b want 1000", req_ready);
    end
    tick();
    req_valid[3] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 8'h21}) begin
      n_fail++;
      $display("FAIL bp_rsp3: got v=%b id=%0d d=%h want 1/3/21",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2, 1'b1, 8'h81, 1'b1, 3'd1);
    tick();
    req_valid[2] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 8'h03}) begin
      n_fail++;
      $display("FAIL mid_pre: got v=%b id=%0d d=%h want 1/2/03",
               rsp_valid, rsp_id, rsp_data);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== 11'h000) begin
      n_fail++;
      $display("FAIL mid_async: got v=%b id=%0d d=%h want 0/0/00",
               rsp_valid, rsp_id, rsp_data);
    end
    set_req(1, 1'b1, 8'h3C, 1'b1, 3'd2);
    set_req(2, 1'b1, 8'h81, 1'b1, 3'd1);
    #1;
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_ready_rst: got %b want 0000", req_ready);
    end
    tick();
    rstn = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_ready_rel: got %b want 0010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'hF0}) begin
      n_fail++;
      $display("FAIL mid_rsp1: got v=%b id=%0d d=%h want 1/1/F0",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
    req_valid[2] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 8'h03}) begin
      n_fail++;
      $display("FAIL mid_rsp2: got v=%b id=%0d d=%h want 1/2/03",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_sparse();
    set_req(1, 1'b1, 8'h55, 1'b0, 3'd1);
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL sparse_ready1: got %b want 0010", req_ready);
    end
    tick();
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'hAA}) begin
      n_fail++;
      $display("FAIL sparse_rsp1: got v=%b id=%0d d=%h want 1/1/AA",
               rsp_valid, rsp_id, rsp_data);
    end
    set_req(2, 1'b1, 8'h01, 1'b1, 3'd3);
    #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL sparse_ready2: got %b want 0100", req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 8'h08}) begin
      n_fail++;
      $display("FAIL sparse_rsp2: got v=%b id=%0d d=%h want 1/2/08",
               rsp_valid, rsp_id, rsp_data);
    end
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL sparse_ready3: got %b want 0010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'hAA}) begin
      n_fail++;
      $display("FAIL sparse_rsp3: got v=%b id=%0d d=%h want 1/1/AA",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
    n_chk++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL sparse_idle: got v=%b busy=%b want 0/0",
               rsp_valid, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sparse();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
